// File: rtl/csr_pkg.sv
// ----------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the CSR cycle unit:
//   - CSR address constants for the cycle (and optional instret) counters
//   - rw_mode encodings (read / CSRRW / CSRRS / CSRRC)
//   - FSM state enum
//   - address decode and read-modify-write helper functions
// Build option: CSR_CYCLE_INSTRET_EN -- when defined, the instret counter
// addresses decode as legal; otherwise they are illegal.
// ----------------------------------------------------------------------------
package csr_pkg;

  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

`ifdef CSR_CYCLE_INSTRET_EN
  localparam logic INSTRET_EN = 1'b1;
`else
  localparam logic INSTRET_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    RW_READ  = 2'b00,
    RW_WRITE = 2'b01,
    RW_SET   = 2'b10,
    RW_CLEAR = 2'b11
  } rw_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  // Result of decoding one CSR address.
  typedef struct packed {
    logic legal;    // address maps to an implemented counter half
    logic ro;       // user-mode read-only alias
    logic hi;       // selects the upper 32 bits
    logic instret;  // selects the instret counter instead of cycle
  } csr_dec_t;

  function automatic csr_dec_t csr_decode(input logic [11:0] addr,
                                          input logic        instret_en);
    csr_dec_t d;
    d = '0;
    case (addr)
      ADDR_MCYCLE:    begin d.legal = 1'b1; end
      ADDR_MCYCLEH:   begin d.legal = 1'b1; d.hi = 1'b1; end
      ADDR_CYCLE:     begin d.legal = 1'b1; d.ro = 1'b1; end
      ADDR_CYCLEH:    begin d.legal = 1'b1; d.ro = 1'b1; d.hi = 1'b1; end
      ADDR_MINSTRET:  begin d.legal = instret_en; d.instret = 1'b1; end
      ADDR_MINSTRETH: begin d.legal = instret_en; d.instret = 1'b1; d.hi = 1'b1; end
      ADDR_INSTRET:   begin d.legal = instret_en; d.instret = 1'b1; d.ro = 1'b1; end
      ADDR_INSTRETH:  begin
        d.legal   = instret_en;
        d.instret = 1'b1;
        d.ro      = 1'b1;
        d.hi      = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  // CSRRS/CSRRC with a zero operand are architecturally plain reads.
  function automatic logic csr_is_write(input rw_mode_e    mode,
                                        input logic [31:0] wdata);
    logic w;
    case (mode)
      RW_READ:  w = 1'b0;
      RW_WRITE: w = 1'b1;
      default:  w = (wdata != 32'h0);
    endcase
    return w;
  endfunction

  function automatic logic [31:0] csr_new_value(input rw_mode_e    mode,
                                                input logic [31:0] old,
                                                input logic [31:0] wdata);
    logic [31:0] v;
    case (mode)
      RW_WRITE: v = wdata;
      RW_SET:   v = old | wdata;
      RW_CLEAR: v = old & ~wdata;
      default:  v = old;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// ----------------------------------------------------------------------------
// csr_counter64
// 64-bit event counter held as two 32-bit halves, each independently
// writable.
// Ports:
//   clk          clock, all state on rising edge
//   reset        synchronous active-high reset, clears both halves
//   i_inc        count enable for this cycle
//   i_wr_lo      load low half with i_wdata_lo (high half holds, no carry)
//   i_wr_hi      load high half with i_wdata_hi (low half keeps counting,
//                any carry out of low this cycle is dropped)
//   i_wdata_lo   low-half write data
//   i_wdata_hi   high-half write data
//   o_value      current 64-bit value {high, low}
// ----------------------------------------------------------------------------
module csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_inc,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wdata_lo,
  input  logic [31:0] i_wdata_hi,
  output logic [63:0] o_value
);

  logic [31:0] r_lo;
  logic [31:0] r_hi;
  logic        w_carry;

  // Carry into the high half only when low really increments past all-ones;
  // a low-half write replaces the increment, so it also suppresses the carry.
  assign w_carry = i_inc && !i_wr_lo && (r_lo == 32'hFFFF_FFFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lo <= 32'h0;
      r_hi <= 32'h0;
    end else begin
      if (i_wr_lo) begin
        r_lo <= i_wdata_lo;
      end else if (i_inc) begin
        r_lo <= r_lo + 32'd1;
      end

      // High-half write wins over a simultaneous carry.
      if (i_wr_hi) begin
        r_hi <= i_wdata_hi;
      end else if (w_carry) begin
        r_hi <= r_hi + 32'd1;
      end
    end
  end

  assign o_value = {r_hi, r_lo};

endmodule

// File: rtl/csr_cycle_unit.sv
// ----------------------------------------------------------------------------
// csr_cycle_unit
// Serves Zicntr/machine cycle-counter CSR accesses from the execute stage.
// One request is accepted in IDLE, answered during the following EXEC cycle
// (rsp_valid for exactly that cycle), and any write commits at the end of
// EXEC. rdata carries the addressed half as it stood at the start of EXEC.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is high only in IDLE outside reset, so at
// most one request is in flight. The response is a single-cycle strobe
// (rsp_valid) with no back-pressure; rdata/rsp_err are zero when it is low.
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   req_valid      request from execute stage
//   req_ready      unit can accept a request
//   csr_addr       CSR address (captured at acceptance)
//   rw_mode        00 read, 01 CSRRW, 10 CSRRS, 11 CSRRC (captured)
//   wdata          write operand (captured)
//   count_inhibit  freezes the cycle counter
//   instret_inc    instret increment (only with CSR_CYCLE_INSTRET_EN)
//   rsp_valid      response strobe
//   rdata          CSR value before the access, 0 on error
//   rsp_err        illegal address or write to a read-only alias
//
// Build option: CSR_CYCLE_INSTRET_EN adds the instret counter at
// 0xB02/0xB82 (RW) and 0xC02/0xC82 (RO) together with the instret_inc input.
// ----------------------------------------------------------------------------
module csr_cycle_unit
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  rw_mode,
  input  logic [31:0] wdata,
  input  logic        count_inhibit,
`ifdef CSR_CYCLE_INSTRET_EN
  input  logic        instret_inc,
`endif
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        rsp_err
);

  // --------------------------------------------------------------------------
  // Request capture and FSM
  // --------------------------------------------------------------------------
  state_e      r_state;
  state_e      w_state_nxt;
  logic [11:0] r_addr;
  rw_mode_e    r_mode;
  logic [31:0] r_wdata;

  logic        w_accept;
  logic        w_exec;

  assign w_accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Reset is folded into both outputs so an EXEC cut short by reset neither
  // responds nor commits, and nothing is accepted while reset is held.
  always_comb begin
    req_ready = 1'b0;
    w_exec    = 1'b0;
    case (r_state)
      ST_IDLE: req_ready = !reset;
      ST_EXEC: w_exec    = !reset;
      default: begin
        req_ready = 1'b0;
        w_exec    = 1'b0;
      end
    endcase
  end

  // Operands are frozen at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr  <= 12'h0;
      r_mode  <= RW_READ;
      r_wdata <= 32'h0;
    end else if (w_accept) begin
      r_addr  <= csr_addr;
      r_mode  <= rw_mode_e'(rw_mode);
      r_wdata <= wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Decode and read-modify-write
  // --------------------------------------------------------------------------
  csr_dec_t    w_dec;
  logic        w_is_wr;
  logic        w_err;
  logic        w_commit;
  logic [63:0] w_cyc_val;
  logic [63:0] w_ins_val;
  logic [63:0] w_cnt_sel;
  logic [31:0] w_old;
  logic [31:0] w_new;

  assign w_dec     = csr_decode(r_addr, INSTRET_EN);
  assign w_is_wr   = csr_is_write(r_mode, r_wdata);
  assign w_err     = !w_dec.legal || (w_dec.ro && w_is_wr);
  assign w_commit  = w_exec && !w_err && w_is_wr;

  assign w_cnt_sel = w_dec.instret ? w_ins_val : w_cyc_val;
  assign w_old     = w_dec.hi ? w_cnt_sel[63:32] : w_cnt_sel[31:0];
  assign w_new     = csr_new_value(r_mode, w_old, r_wdata);

  // Per-counter, per-half write strobes.
  logic w_cyc_wr_lo;
  logic w_cyc_wr_hi;

  assign w_cyc_wr_lo = w_commit && !w_dec.instret && !w_dec.hi;
  assign w_cyc_wr_hi = w_commit && !w_dec.instret &&  w_dec.hi;

  // --------------------------------------------------------------------------
  // Counters
  // --------------------------------------------------------------------------
  csr_counter64 u_cycle (
    .clk        (clk),
    .reset      (reset),
    .i_inc      (!count_inhibit),
    .i_wr_lo    (w_cyc_wr_lo),
    .i_wr_hi    (w_cyc_wr_hi),
    .i_wdata_lo (w_new),
    .i_wdata_hi (w_new),
    .o_value    (w_cyc_val)
  );

`ifdef CSR_CYCLE_INSTRET_EN
  logic w_ins_wr_lo;
  logic w_ins_wr_hi;

  assign w_ins_wr_lo = w_commit && w_dec.instret && !w_dec.hi;
  assign w_ins_wr_hi = w_commit && w_dec.instret &&  w_dec.hi;

  csr_counter64 u_instret (
    .clk        (clk),
    .reset      (reset),
    .i_inc      (instret_inc),
    .i_wr_lo    (w_ins_wr_lo),
    .i_wr_hi    (w_ins_wr_hi),
    .i_wdata_lo (w_new),
    .i_wdata_hi (w_new),
    .o_value    (w_ins_val)
  );
`else
  // No instret counter: its addresses decode as illegal, so this value is
  // never returned.
  assign w_ins_val = 64'h0;
`endif

  // --------------------------------------------------------------------------
  // Response
  // --------------------------------------------------------------------------
  always_comb begin
    rsp_valid = w_exec;
    rsp_err   = 1'b0;
    rdata     = 32'h0;
    if (w_exec) begin
      rsp_err = w_err;
      rdata   = w_err ? 32'h0 : w_old;
    end
  end

endmodule

// File: doc/csr_cycle_unit.md
CSR_CYCLE_UNIT -- requirements
Module: csr_cycle_unit

Interface
REQ-001 SHALL have these ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have these ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have these ports: req_valid  in  1  CSR access request from execute stage.
REQ-004 SHALL have these ports: req_ready  out  1  unit can accept a request.
REQ-005 SHALL have these ports: csr_addr  in  12  CSR address.
REQ-006 SHALL have these ports: rw_mode  in  2  00 read, 01 CSRRW, 10 CSRRS, 11 CSRRC.
REQ-007 SHALL have these ports: wdata  in  32  write operand (rs1/imm value).
REQ-008 SHALL have these ports: count_inhibit  in  1  mcountinhibit.CY, freezes cycle counter.
REQ-009 SHALL have these ports: rsp_valid  out  1  one-cycle response strobe.
REQ-010 SHALL have these ports: rdata  out  32  CSR value before the access.
REQ-011 SHALL have these ports: rsp_err  out  1  illegal address or write to read-only CSR.

Function
REQ-012 SHALL hold a 64-bit cycle counter as a 32-bit low half and a 32-bit high half; high increments on low-half carry (low == 0xFFFF_FFFF and incrementing).
REQ-013 SHALL increment the counter by 1 every cycle unless count_inhibit=1 or a write to that counter commits that cycle.
REQ-014 SHALL decode: 0xB00 mcycle (RW, low), 0xB80 mcycleh (RW, high), 0xC00 cycle (RO, low), 0xC80 cycleh (RO, high); all other addresses illegal.
REQ-015 SHALL implement FSM IDLE, EXEC: IDLE -> EXEC on req_valid && req_ready; EXEC -> IDLE unconditionally.
REQ-016 SHALL drive req_ready=1 only in IDLE and when reset=0.
REQ-017 SHALL capture csr_addr, rw_mode, wdata at acceptance; input changes after acceptance are ignored.
REQ-018 SHALL assert rsp_valid for exactly the EXEC cycle (latency 1 cycle after accept, throughput one request per 2 cycles).
REQ-019 SHALL return in rdata the addressed half as registered at the start of EXEC (pre-increment, pre-write).
REQ-020 SHALL compute new value: RW -> wdata; RS -> old | wdata; RC -> old & ~wdata; committed at end of EXEC.
REQ-021 SHALL treat rw_mode 00, and RS/RC with wdata == 0, as read-only accesses: no write, counting unaffected.
REQ-022 SHALL, on low-half write, load low with new value and hold high (no carry that cycle).
REQ-023 SHALL, on high-half write, load high with new value while low continues counting; any low carry that cycle is discarded (write wins).
REQ-024 SHALL, on illegal address or a write to 0xC00/0xC80, assert rsp_err=1, drive rdata=0, change no state.
REQ-025 SHALL drive rdata=0 and rsp_err=0 whenever rsp_valid=0.

Reset
REQ-026 SHALL, with reset=1 at a rising edge, set counter=0, state=IDLE, rsp_valid=0, rdata=0, rsp_err=0.
REQ-027 SHALL abort an in-flight EXEC on reset: no response, no write commit.
REQ-028 SHALL not count during a reset cycle; first increment occurs on the first edge with reset=0.

Configuration
REQ-029 SHALL, with CSR_CYCLE_INSTRET_EN defined, add input instret_inc (1 bit) and a second 64-bit counter at 0xB02/0xB82 (RW) and 0xC02/0xC82 (RO), incrementing when instret_inc=1, same access rules as REQ-019..REQ-024.
REQ-030 SHALL, without CSR_CYCLE_INSTRET_EN, omit instret_inc and treat 0xB02/0xB82/0xC02/0xC82 as illegal.

Structure
REQ-031 SHALL place CSR address constants, rw_mode encodings and FSM state enum in shared package csr_pkg.
REQ-032 SHALL implement each 64-bit counter as sub-module csr_counter64 (inc enable, per-half write enable and data, 64-bit value out), instantiated once, or twice with the macro.

Verification
REQ-033 SHALL cover: reset, release, 10 idle cycles, read 0xB00 -> rsp_valid one cycle later, rdata=counter value at EXEC, rsp_err=0.
REQ-034 SHALL cover: CSRRW 0xB00 wdata=0xFFFF_FFFE -> next cycles low 0xFFFF_FFFF then 0x0000_0000, high +1; read 0xB80 returns 1.
REQ-035 SHALL cover: CSRRW 0xB80 wdata=0x5 timed where low wraps -> high=0x5 (carry dropped), low=0.
REQ-036 SHALL cover: CSRRS 0xB00 wdata=0 -> no write, counter keeps counting; CSRRC 0xC80 wdata=1 -> rsp_err=1, rdata=0, counter unaffected.
REQ-037 SHALL cover: count_inhibit=1 for 20 cycles -> counter constant; read 0x123 -> rsp_err=1; reset asserted during EXEC -> no rsp_valid, counter=0.
REQ-038 SHALL cover: with CSR_CYCLE_INSTRET_EN, 7 instret_inc pulses then read 0xC02 -> rdata=7; without it, read 0xC02 -> rsp_err=1.
